// File: rtl/curve25519_pkg.sv
// Shared constants and types for the Curve25519 field datapath.
// Field prime p = 2^255-19, the Fermat inversion exponent and the exponentiator state type.
package curve25519_pkg;

   localparam int N = 255;

   localparam logic [N-1:0] P         = {N{1'b1}} - N'(18);
   localparam logic [N-1:0] P_MINUS_2 = {N{1'b1}} - N'(20);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SCAN      = 3'd1,
      S_SQR_ISSUE = 3'd2,
      S_SQR_WAIT  = 3'd3,
      S_MUL_ISSUE = 3'd4,
      S_MUL_WAIT  = 3'd5,
      S_FIN       = 3'd6
   } pow_state_t;

endpackage

// File: rtl/pow_modp.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod p.
// Drives an external mod-p multiplier through the mul_* ports.
module pow_modp #(
   parameter int N           = 255,
   parameter int MUL_TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] base,
   input  logic [N-1:0] exp,
   output logic [N-1:0] result,
   output logic         done,
   output logic         busy,
   output logic         err,
   output logic         mul_rst_n,
   output logic [N-1:0] mul_x,
   output logic [N-1:0] mul_y,
   input  logic [N-1:0] mul_prod,
   input  logic         mul_data_rdy,
   output logic [2:0]   dbg_state
);
   import curve25519_pkg::*;

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MUL_TIMEOUT + 2);

   pow_state_t     r_state,  w_state_nxt;
   logic [N-1:0]   r_base,   w_base_nxt;
   logic [N-1:0]   r_exp,    w_exp_nxt;
   logic [N-1:0]   r_acc,    w_acc_nxt;
   logic [N-1:0]   r_result, w_result_nxt;
   logic [N-1:0]   r_mul_x,  w_mul_x_nxt;
   logic [N-1:0]   r_mul_y,  w_mul_y_nxt;
   logic [IW-1:0]  r_idx,    w_idx_nxt;
   logic [CW-1:0]  r_wcnt,   w_wcnt_nxt;
   logic           r_done,   w_done_nxt;
   logic           r_err,    w_err_nxt;
   logic           w_rdy_ok;
   logic           w_tmo;

   // A product is only trusted from the second wait cycle on: the multiplier may
   // still present the ready of its previous run in the first cycle after restart.
   assign w_rdy_ok = (r_wcnt != '0) && mul_data_rdy;
   assign w_tmo    = r_wcnt > CW'(MUL_TIMEOUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_exp    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_mul_x  <= '0;
         r_mul_y  <= '0;
         r_idx    <= '0;
         r_wcnt   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_base   <= w_base_nxt;
         r_exp    <= w_exp_nxt;
         r_acc    <= w_acc_nxt;
         r_result <= w_result_nxt;
         r_mul_x  <= w_mul_x_nxt;
         r_mul_y  <= w_mul_y_nxt;
         r_idx    <= w_idx_nxt;
         r_wcnt   <= w_wcnt_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_base_nxt   = r_base;
      w_exp_nxt    = r_exp;
      w_acc_nxt    = r_acc;
      w_result_nxt = r_result;
      w_mul_x_nxt  = r_mul_x;
      w_mul_y_nxt  = r_mul_y;
      w_idx_nxt    = r_idx;
      w_wcnt_nxt   = r_wcnt;
      w_done_nxt   = 1'b0;
      w_err_nxt    = r_err;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_base_nxt = base;
               w_exp_nxt  = exp;
               w_err_nxt  = 1'b0;
               if (exp == '0) begin
                  w_acc_nxt   = N'(1);
                  w_state_nxt = S_FIN;
               end else begin
                  w_idx_nxt   = IW'(N - 1);
                  w_state_nxt = S_SCAN;
               end
            end
         end
         // Walk down from the top bit until the leading one is found.
         S_SCAN: begin
            if (r_exp[r_idx]) begin
               w_acc_nxt = r_base;
               if (r_idx == '0) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_idx_nxt   = r_idx - IW'(1);
                  w_state_nxt = S_SQR_ISSUE;
               end
            end else begin
               w_idx_nxt = r_idx - IW'(1);
            end
         end
         S_SQR_ISSUE: begin
            w_wcnt_nxt  = '0;
            w_state_nxt = S_SQR_WAIT;
         end
         S_MUL_ISSUE: begin
            w_wcnt_nxt  = '0;
            w_state_nxt = S_MUL_WAIT;
         end
         S_SQR_WAIT, S_MUL_WAIT: begin
            if (w_rdy_ok) begin
               w_acc_nxt = mul_prod;
               if (r_state == S_SQR_WAIT && r_exp[r_idx]) begin
                  w_state_nxt = S_MUL_ISSUE;
               end else if (r_idx == '0) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_idx_nxt   = r_idx - IW'(1);
                  w_state_nxt = S_SQR_ISSUE;
               end
            end else if (w_tmo) begin
               w_err_nxt    = 1'b1;
               w_result_nxt = '0;
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_IDLE;
            end else begin
               w_wcnt_nxt = r_wcnt + CW'(1);
            end
         end
         S_FIN: begin
            w_result_nxt = r_acc;
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Operands are loaded on entry to an issue cycle and held through the wait.
      if (w_state_nxt == S_SQR_ISSUE) begin
         w_mul_x_nxt = w_acc_nxt;
         w_mul_y_nxt = w_acc_nxt;
      end else if (w_state_nxt == S_MUL_ISSUE) begin
         w_mul_x_nxt = w_acc_nxt;
         w_mul_y_nxt = r_base;
      end
   end

   assign result    = r_result;
   assign done      = r_done;
   assign err       = r_err;
   assign busy      = (r_state != S_IDLE);
   assign mul_rst_n = (r_state == S_SQR_WAIT) || (r_state == S_MUL_WAIT);
   assign mul_x     = r_mul_x;
   assign mul_y     = r_mul_y;
   assign dbg_state = r_state;

endmodule
